// File: rtl/decode_stage_if.sv
// Handshake bundles around the decode stage: instruction stream in, decoded bundle out.
// The master modport drives the data and valid; the slave modport returns ready.
interface instrBusIf #(
  parameter int INSTR_W = 32
);
  logic               inValid;
  logic               inReady;
  logic [INSTR_W-1:0] instruction;

  modport master (output inValid, output instruction, input inReady);
  modport slave  (input inValid, input instruction, output inReady);
endinterface

interface decodeBusIf #(
  parameter int REG_ADDR_W = 4,
  parameter int DATA_W     = 32,
  parameter int SHIFT_W    = 4
);
  logic                  outValid;
  logic                  outReady;
  logic [1:0]            operation;
  logic [2:0]            func;
  logic [REG_ADDR_W-1:0] dest;
  logic [REG_ADDR_W-1:0] addrA;
  logic [REG_ADDR_W-1:0] addrB;
  logic [SHIFT_W-1:0]    shiftBits;
  logic [DATA_W-1:0]     immediate;
  logic                  regWrite;
  logic                  memRead;
  logic                  memWrite;
  logic                  jump;
  logic                  illegal;

  modport master (
    output outValid, operation, func, dest, addrA, addrB, shiftBits, immediate,
    output regWrite, memRead, memWrite, jump, illegal,
    input  outReady
  );
  modport slave (
    input  outValid, operation, func, dest, addrA, addrB, shiftBits, immediate,
    input  regWrite, memRead, memWrite, jump, illegal,
    output outReady
  );
endinterface

// File: rtl/decode_stage.sv
// Registered instruction decode stage with prefix-extended immediates and flush.
// Optional: define DECODE_ILLEGAL_TRAP_EN to emit an illegal-flagged bundle for bad encodings.
//
// state   | meaning
// IDLE    | no prefix held; immediates are sign-extended
// PENDING | prefixImm holds the upper immediate for the next instruction
module decode_stage #(
  parameter int INSTR_W    = 32,
  parameter int REG_ADDR_W = 4,
  parameter int DATA_W     = 32,
  parameter int SHIFT_W    = 4
) (
  input  logic clk,
  input  logic resetN,
  input  logic flush,
  instrBusIf.slave   inBus,
  decodeBusIf.master outBus
);

  localparam int IMM_W = INSTR_W - 5 - 3*REG_ADDR_W;

  typedef enum logic {IDLE, PENDING} stateType;

  stateType state, stateNext;

  logic [1:0]            opField;
  logic [2:0]            funcField;
  logic [REG_ADDR_W-1:0] destField, aField, bField;
  logic [IMM_W-1:0]      immField;
  logic [IMM_W-1:0]      prefixImm;
  logic [DATA_W-1:0]     immSext, immJoined, immNext;

  logic isPrefix, isIllegal;
  logic decRegWrite, decMemRead, decMemWrite, decJump;
  logic accept, loadBundle, latchPrefix, validNext;

  logic                  outValidQ;
  logic [1:0]            operationQ;
  logic [2:0]            funcQ;
  logic [REG_ADDR_W-1:0] destQ, addrAQ, addrBQ;
  logic [SHIFT_W-1:0]    shiftBitsQ;
  logic [DATA_W-1:0]     immediateQ;
  logic                  regWriteQ, memReadQ, memWriteQ, jumpQ;

  assign opField   = inBus.instruction[INSTR_W-1 -: 2];
  assign funcField = inBus.instruction[INSTR_W-3 -: 3];
  assign destField = inBus.instruction[INSTR_W-6 -: REG_ADDR_W];
  assign aField    = inBus.instruction[INSTR_W-6-REG_ADDR_W -: REG_ADDR_W];
  assign bField    = inBus.instruction[INSTR_W-6-2*REG_ADDR_W -: REG_ADDR_W];
  assign immField  = inBus.instruction[IMM_W-1:0];

  always_comb begin
    isPrefix    = 1'b0;
    isIllegal   = 1'b0;
    decRegWrite = 1'b0;
    decMemRead  = 1'b0;
    decMemWrite = 1'b0;
    decJump     = 1'b0;
    case (opField)
      2'b00, 2'b01: decRegWrite = 1'b1;
      2'b10: begin
        case (funcField)
          3'b000: begin
            decMemRead  = 1'b1;
            decRegWrite = 1'b1;
          end
          3'b001:  decMemWrite = 1'b1;
          3'b111:  isPrefix    = 1'b1;
          default: isIllegal   = 1'b1;
        endcase
      end
      default: decJump = 1'b1;
    endcase
  end

  // A pending prefix supplies the upper bits; the joined value is zero-extended.
  assign immSext   = DATA_W'(signed'(immField));
  assign immJoined = DATA_W'({prefixImm, immField});
  assign immNext   = (state == PENDING) ? immJoined : immSext;

  assign inBus.inReady = !outValidQ || outBus.outReady || flush;
  assign accept        = inBus.inValid && inBus.inReady;

  always_ff @(posedge clk) begin
    if (!resetN) state <= IDLE;
    else         state <= stateNext;
  end

  // Accepting without flush implies the held bundle is gone, so validNext is already 0.
  always_comb begin
    stateNext   = state;
    loadBundle  = 1'b0;
    latchPrefix = 1'b0;
    validNext   = outValidQ && !outBus.outReady;
    if (flush) begin
      stateNext = IDLE;
      validNext = 1'b0;
    end else if (accept) begin
      if (isPrefix) begin
        latchPrefix = 1'b1;
        stateNext   = PENDING;
      end else if (isIllegal) begin
        stateNext = IDLE;
`ifdef DECODE_ILLEGAL_TRAP_EN
        loadBundle = 1'b1;
        validNext  = 1'b1;
`endif
      end else begin
        stateNext  = IDLE;
        loadBundle = 1'b1;
        validNext  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) prefixImm <= '0;
    else if (latchPrefix) prefixImm <= immField;
  end

  // Illegal encodings decode with every strobe low, so the bundle load needs no masking.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      outValidQ  <= 1'b0;
      operationQ <= '0;
      funcQ      <= '0;
      destQ      <= '0;
      addrAQ     <= '0;
      addrBQ     <= '0;
      shiftBitsQ <= '0;
      immediateQ <= '0;
      regWriteQ  <= 1'b0;
      memReadQ   <= 1'b0;
      memWriteQ  <= 1'b0;
      jumpQ      <= 1'b0;
    end else begin
      outValidQ <= validNext;
      if (loadBundle) begin
        operationQ <= opField;
        funcQ      <= funcField;
        destQ      <= destField;
        addrAQ     <= aField;
        addrBQ     <= bField;
        shiftBitsQ <= immField[SHIFT_W-1:0];
        immediateQ <= immNext;
        regWriteQ  <= decRegWrite;
        memReadQ   <= decMemRead;
        memWriteQ  <= decMemWrite;
        jumpQ      <= decJump;
      end
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegalQ;

  always_ff @(posedge clk) begin
    if (!resetN)         illegalQ <= 1'b0;
    else if (loadBundle) illegalQ <= isIllegal;
  end

  assign outBus.illegal = illegalQ;
`else
  assign outBus.illegal = 1'b0;
`endif

  assign outBus.outValid  = outValidQ;
  assign outBus.operation = operationQ;
  assign outBus.func      = funcQ;
  assign outBus.dest      = destQ;
  assign outBus.addrA     = addrAQ;
  assign outBus.addrB     = addrBQ;
  assign outBus.shiftBits = shiftBitsQ;
  assign outBus.immediate = immediateQ;
  assign outBus.regWrite  = regWriteQ;
  assign outBus.memRead   = memReadQ;
  assign outBus.memWrite  = memWriteQ;
  assign outBus.jump      = jumpQ;

endmodule

// File: tb/tb_decode_stage.sv
// Directed and random bench for decode_stage, checked against a cycle-level reference model.
module tb_decode_stage;

  localparam int IW = 32;
  localparam int RA = 4;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic resetN;
  logic flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instrBusIf  #(.INSTR_W(IW)) inBus();
  decodeBusIf #(.REG_ADDR_W(RA), .DATA_W(DW), .SHIFT_W(SW)) outBus();

  decode_stage #(
    .INSTR_W(IW), .REG_ADDR_W(RA), .DATA_W(DW), .SHIFT_W(SW)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .flush(flush),
    .inBus(inBus),
    .outBus(outBus)
  );

  // Reference model state, advanced once per clock edge.
  bit          mValid, mPending;
  longint      mPimm;
  logic [1:0]  mOp;
  logic [2:0]  mFunc;
  logic [3:0]  mDest, mA, mB, mShift;
  logic [31:0] mImm;
  bit          mRegW, mMemR, mMemW, mJump, mIll;

  function automatic logic [31:0] mkInstr(input int op, input int fn, input int d,
                                          input int a, input int b, input int imm);
    longint x;
    x = (longint'(op & 3) << 30) | (longint'(fn & 7) << 27) | (longint'(d & 15) << 23)
      | (longint'(a & 15) << 19) | (longint'(b & 15) << 15) | longint'(imm & 'h7FFF);
    return x[31:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelEdge(input bit v, input logic [31:0] ins, input bit rdy,
                           input bit fl, input bit rst);
    longint op, fn, imm, val;
    bit     rdyIn, ill;
    rdyIn = !mValid || rdy || fl;
    op  = (longint'(ins) >> 30) & 3;
    fn  = (longint'(ins) >> 27) & 7;
    imm = longint'(ins) & 'h7FFF;
    if (!rst) begin
      mValid = 0; mPending = 0; mPimm = 0;
      mOp = '0; mFunc = '0; mDest = '0; mA = '0; mB = '0; mShift = '0; mImm = '0;
      mRegW = 0; mMemR = 0; mMemW = 0; mJump = 0; mIll = 0;
    end else if (fl) begin
      mValid = 0; mPending = 0;
    end else if (v && rdyIn) begin
      if (op == 2 && fn == 7) begin
        mPending = 1; mPimm = imm; mValid = 0;
      end else begin
        ill    = (op == 2 && fn != 0 && fn != 1);
        mOp    = 2'(op);
        mFunc  = 3'(fn);
        mDest  = 4'((longint'(ins) >> 23) & 15);
        mA     = 4'((longint'(ins) >> 19) & 15);
        mB     = 4'((longint'(ins) >> 15) & 15);
        mShift = 4'(imm & 15);
        if (mPending) val = (mPimm * 32768 + imm) & 'hFFFF_FFFF;
        else if (imm >= 16384) val = imm + 'hFFFF_8000;
        else val = imm;
        mImm  = 32'(val);
        mRegW = !ill && (op == 0 || op == 1 || (op == 2 && fn == 0));
        mMemR = (op == 2 && fn == 0);
        mMemW = (op == 2 && fn == 1);
        mJump = (op == 3);
        mPending = 0;
`ifdef DECODE_ILLEGAL_TRAP_EN
        mIll   = ill;
        mValid = 1;
`else
        mIll   = 0;
        mValid = !ill;
`endif
      end
    end else if (rdy) begin
      mValid = 0;
    end
  endtask

  task automatic step(input bit v, input logic [31:0] ins, input bit rdy,
                      input bit fl = 1'b0, input bit rst = 1'b1);
    inBus.inValid      = v;
    inBus.instruction  = ins;
    outBus.outReady    = rdy;
    flush              = fl;
    resetN             = rst;
    #2;
    if (rst) check("inReady", inBus.inReady, !mValid || rdy || fl);
    modelEdge(v, ins, rdy, fl, rst);
    @(posedge clk);
    #1;
    check("outValid", outBus.outValid, mValid);
    if (mValid || !rst) begin
      check("operation", outBus.operation, mOp);
      check("func", outBus.func, mFunc);
      check("dest", outBus.dest, mDest);
      check("addrA", outBus.addrA, mA);
      check("addrB", outBus.addrB, mB);
      check("shiftBits", outBus.shiftBits, mShift);
      check("immediate", outBus.immediate, mImm);
      check("regWrite", outBus.regWrite, mRegW);
      check("memRead", outBus.memRead, mMemR);
      check("memWrite", outBus.memWrite, mMemW);
      check("jump", outBus.jump, mJump);
      check("illegal", outBus.illegal, mIll);
    end
  endtask

  initial begin
    logic [31:0] insA, insB, ins;
    int          r, op, fn;

    inBus.inValid = 0; inBus.instruction = '0; outBus.outReady = 1; flush = 0; resetN = 0;
    mValid = 0; mPending = 0; mPimm = 0;

    // Reset
    step(0, '0, 1, 0, 0);
    step(0, '0, 1, 0, 0);
    step(0, '0, 1);

    // Plain reg-reg ALU op
    step(1, mkInstr(0, 2, 3, 5, 7, 0), 1);
    check("t1_valid", outBus.outValid, 1);
    check("t1_func", outBus.func, 3'b010);
    check("t1_dest", outBus.dest, 3);
    check("t1_addrA", outBus.addrA, 5);
    check("t1_addrB", outBus.addrB, 7);
    check("t1_regWrite", outBus.regWrite, 1);
    check("t1_strobes", {outBus.memRead, outBus.memWrite, outBus.jump}, 0);

    // Negative immediate sign extension
    step(1, mkInstr(1, 0, 1, 2, 3, 'h7FF3), 1);
    check("t2_imm", outBus.immediate, 32'hFFFF_FFF3);
    check("t2_shift", outBus.shiftBits, 3);

    // Prefix joins immediates, then returns to sign extension
    step(1, mkInstr(2, 7, 0, 0, 0, 'h1A), 1);
    check("t3_prefix_noout", outBus.outValid, 0);
    step(1, mkInstr(2, 0, 4, 1, 0, 'h1234), 1);
    check("t3_joined_imm", outBus.immediate, 32'h000D_1234);
    check("t3_memRead", outBus.memRead, 1);
    step(1, mkInstr(2, 0, 4, 1, 0, 'h4001), 1);
    check("t3_after_imm", outBus.immediate, 32'hFFFF_C001);

    // Back-pressure
    step(0, '0, 1);
    insA = mkInstr(0, 1, 6, 2, 9, 0);
    insB = mkInstr(3, 4, 0, 8, 0, 'h20);
    step(1, insA, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, insB, 0);
      check("t4_hold_dest", outBus.dest, 6);
      check("t4_inReady", inBus.inReady, 0);
    end
    step(1, insB, 1);
    check("t4_second_jump", outBus.jump, 1);
    check("t4_second_addrA", outBus.addrA, 8);
    step(0, '0, 1);
    check("t4_drained", outBus.outValid, 0);

    // Flush with a held bundle, then with a pending prefix
    step(1, insA, 0);
    step(1, mkInstr(2, 7, 0, 0, 0, 'h55), 0, 1);
    check("t5_flush_held", outBus.outValid, 0);
    step(1, mkInstr(2, 7, 0, 0, 0, 'h55), 1);
    step(1, insA, 0, 1);
    check("t5_flush_pend", outBus.outValid, 0);
    step(1, mkInstr(2, 0, 2, 3, 0, 'h7FFF), 1);
    check("t5_plain_imm", outBus.immediate, 32'hFFFF_FFFF);

    // Illegal encoding, and illegal clearing a pending prefix
    step(1, mkInstr(2, 3, 1, 1, 1, 5), 1);
`ifdef DECODE_ILLEGAL_TRAP_EN
    check("t6_trap_valid", outBus.outValid, 1);
    check("t6_trap_flag", outBus.illegal, 1);
    check("t6_trap_strobes",
          {outBus.regWrite, outBus.memRead, outBus.memWrite, outBus.jump}, 0);
`else
    check("t6_silent", outBus.outValid, 0);
`endif
    step(1, mkInstr(2, 7, 0, 0, 0, 'h3), 1);
    step(1, mkInstr(2, 5, 0, 0, 0, 0), 1);
    step(1, mkInstr(2, 0, 1, 1, 0, 'h10), 1);
    check("t6_cleared_imm", outBus.immediate, 32'h10);

    // Reset in the middle of a stall
    step(1, insA, 1);
    step(1, insB, 0);
    step(1, insB, 0, 0, 0);
    check("t6_reset_valid", outBus.outValid, 0);
    check("t6_reset_imm", outBus.immediate, 0);
    step(0, '0, 1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2)       begin op = 2; fn = 7; end
      else if (r == 2) begin op = 2; fn = $urandom_range(2, 6); end
      else if (r == 3) begin op = 2; fn = 0; end
      else if (r == 4) begin op = 2; fn = 1; end
      else begin
        op = $urandom_range(0, 2);
        if (op == 2) op = 3;
        fn = $urandom_range(0, 7);
      end
      ins = mkInstr(op, fn, $urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(0, 15), $urandom_range(0, 'h7FFF));
      step($urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 59) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
